fft_butterfly_scheduler: RTL and testbench
==========================================

FFT_BUTTERFLY_SCHEDULER -- requirements
Module: fft_butterfly_scheduler

Interface
REQ-001 SHALL have parameter FFT_N, default 10, meaning log2 of FFT length (N = 2**FFT_N, N/2 butterflies per stage).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse that begins a full FFT pass.
REQ-005 SHALL have port rd_addr_a  output  FFT_N  read address of upper butterfly operand.
REQ-006 SHALL have port rd_addr_b  output  FFT_N  read address of lower butterfly operand.
REQ-007 SHALL have port twiddle_addr  output  FFT_N-1  twiddle ROM address.
REQ-008 SHALL have port rd_en  output  1  read strobe for operand memory and twiddle ROM.
REQ-009 SHALL have port iact  output  1  butterfly input valid, rd_en delayed 1 cycle.
REQ-010 SHALL have port ictrl  output  2  bit0 = first butterfly of stage, bit1 = final butterfly of final stage; aligned with iact.
REQ-011 SHALL have port bfly_index  output  FFT_N-1  butterfly index k, aligned with iact.
REQ-012 SHALL have port oact  input  1  completion strobe from butterfly pipeline.
REQ-013 SHALL have port stage  output  $clog2(FFT_N)  current stage number.
REQ-014 SHALL have ports busy (output, 1, high from start acceptance to done) and done (output, 1, one-cycle pulse at pass end).

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-016 IDLE: start=1 -> ISSUE with stage=0, k=0, completion count=0; start ignored in all other states.
REQ-017 ISSUE: one butterfly per cycle, rd_en=1; after k=N/2-1, go to DRAIN.
REQ-018 Addressing for stage s, span=N>>(s+1), group=k/span, pos=k%span: rd_addr_a=group*2*span+pos, rd_addr_b=rd_addr_a+span, twiddle_addr=pos<<s.
REQ-019 Completion counter SHALL increment on every oact in ISSUE or DRAIN, including oact in the same cycle as a state transition.
REQ-020 DRAIN: rd_en=0; when count reaches N/2, either stage<FFT_N-1 -> stage+1, k=0, count=0, ISSUE; or -> DONE.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; busy deasserts together with done.
REQ-022 oact in IDLE or DONE SHALL be ignored.
REQ-023 Count overflow (more than N/2 oact in a stage) SHALL saturate at N/2.
REQ-024 iact, ictrl, bfly_index SHALL equal rd_en and the corresponding k/flags registered one cycle later.

Reset
REQ-025 reset=0 SHALL immediately force IDLE, stage=0, k=0, count=0, and all outputs to 0, including mid-pass.
REQ-026 After reset release, first start SHALL run a complete pass from stage 0.

Configuration
REQ-027 With macro FFT_SCHED_STALL_EN defined: add input stall (1 bit); stall=1 in ISSUE holds k, rd_en=0, iact=0 the next cycle; DRAIN counting unaffected.
REQ-028 Without FFT_SCHED_STALL_EN: no stall port; ISSUE never pauses.

Verification
REQ-029 FFT_N=3, start pulse -> stage 0 rd_addr_a/b pairs (0,4),(1,5),(2,6),(3,7), twiddle 0,1,2,3, ictrl[0]=1 only with k=0.
REQ-030 FFT_N=3, stage 1 -> pairs (0,2),(1,3),(4,6),(5,7), twiddle 0,2,0,2; stage 2 -> (0,1),(2,3),(4,5),(6,7), twiddle all 0.
REQ-031 Model oact 6 cycles after iact -> DRAIN lasts until 4th oact; next stage issue starts next cycle; done pulses once after stage 2; ictrl=2'b10 on the final butterfly, 2'b00 on the other butterflies of stage 2 except ictrl[0] on k=0.
REQ-032 Assert reset=0 during stage 1 ISSUE -> all outputs 0 same cycle; after release, start -> rd_addr (0,4) first.
REQ-033 start pulsed while busy, and oact pulsed in IDLE -> no effect on stage, count, or done.
REQ-034 With FFT_SCHED_STALL_EN, stall=1 for 3 cycles at k=2 of stage 0 -> iact gap of 3 cycles, k=2 issued after release, pass totals 12 iacts.

Source files
------------

// File: rtl/fft_butterfly_scheduler.sv
// fft_butterfly_scheduler
//   Walks an in-place radix-2 DIF FFT of N = 2**FFT_N points: for every
//   stage it issues N/2 butterflies (operand addresses plus twiddle address),
//   then waits for the butterfly pipeline to report N/2 completions before
//   moving to the next stage.
//
//   Optional feature: define FFT_SCHED_STALL_EN to add a 'stall' input that
//   pauses issue. The default build has no stall port, and issue never pauses.
//
//   Strobe semantics: rd_en is a single-cycle read strobe that carries
//   rd_addr_a/rd_addr_b/twiddle_addr in the same cycle. iact/ictrl/bfly_index
//   are the same strobe registered one cycle later. oact is a single-cycle
//   completion strobe from the pipeline and is counted only while a pass is
//   in ISSUE or DRAIN. There is no back-pressure, apart from 'stall' when it
//   is enabled. All address and control outputs are zero whenever rd_en or
//   iact is low.
module fft_butterfly_scheduler #(
  parameter int FFT_N = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
`ifdef FFT_SCHED_STALL_EN
  input  logic                       stall,
`endif
  output logic [FFT_N-1:0]           rd_addr_a,
  output logic [FFT_N-1:0]           rd_addr_b,
  output logic [FFT_N-2:0]           twiddle_addr,
  output logic                       rd_en,
  output logic                       iact,
  output logic [1:0]                 ictrl,
  output logic [FFT_N-2:0]           bfly_index,
  input  logic                       oact,
  output logic [$clog2(FFT_N)-1:0]   stage,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 state_dbg
);

  localparam int SW = $clog2(FFT_N);
  localparam int KW = FFT_N - 1;
  localparam int CW = FFT_N;

  localparam logic [SW-1:0] LAST_STAGE = SW'(FFT_N - 1);
  localparam logic [KW-1:0] K_LAST     = {KW{1'b1}};
  localparam logic [CW-1:0] CNT_FULL   = {1'b1, {(CW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_upd;
  logic          rd_en_c;
  logic          stall_w;

  logic          iact_q;
  logic [1:0]    ictrl_q;
  logic [KW-1:0] bfly_q;

`ifdef FFT_SCHED_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // Completion count with this cycle's oact folded in, saturating at N/2.
  always_comb begin
    cnt_upd = cnt_q;
    if ((state_q == S_ISSUE || state_q == S_DRAIN) && oact && (cnt_q != CNT_FULL))
      cnt_upd = cnt_q + CW'(1);
  end

  // Next-state logic: issue sequencing, stage advance and completion tracking.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    rd_en_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          k_d     = '0;
          stage_d = '0;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_upd;
        if (!stall_w) begin
          rd_en_c = 1'b1;
          if (k_q == K_LAST) state_d = S_DRAIN;
          else               k_d     = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_upd;
        // The oact arriving this cycle counts, so the next stage issues the
        // cycle right after the final completion.
        if (cnt_upd == CNT_FULL) begin
          if (stage_q != LAST_STAGE) begin
            state_d = S_ISSUE;
            stage_d = stage_q + SW'(1);
            k_d     = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any pass in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address generation: insert a zero bit at position (FFT_N-1-stage) into k
  // to get the upper operand, and set that bit to get the lower operand. The
  // bits of k below that position are the position within the group, and
  // that value shifted left by the stage number is the twiddle index.
  logic [SW-1:0]    shamt;
  logic [FFT_N-1:0] span_bit;
  logic [KW-1:0]    pos_mask;
  logic [KW-1:0]    pos;
  logic [KW-1:0]    hi;
  logic [FFT_N-1:0] addr_a;
  logic [KW-1:0]    tw;

  // Combinational butterfly address and twiddle computation for the current k.
  always_comb begin
    shamt    = LAST_STAGE - stage_q;
    span_bit = FFT_N'(1) << shamt;
    pos_mask = KW'(span_bit - FFT_N'(1));
    pos      = k_q & pos_mask;
    hi       = k_q & ~pos_mask;
    addr_a   = {hi, 1'b0} | {1'b0, pos};
    tw       = pos << stage_q;
  end

  assign rd_en        = rd_en_c;
  assign rd_addr_a    = rd_en_c ? addr_a              : '0;
  assign rd_addr_b    = rd_en_c ? (addr_a | span_bit) : '0;
  assign twiddle_addr = rd_en_c ? tw                  : '0;

  // Butterfly-side strobe and tags, one cycle behind the read strobe so
  // they line up with the operand memory output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iact_q  <= 1'b0;
      ictrl_q <= 2'b00;
      bfly_q  <= '0;
    end else begin
      iact_q     <= rd_en_c;
      ictrl_q[0] <= rd_en_c && (k_q == '0);
      ictrl_q[1] <= rd_en_c && (k_q == K_LAST) && (stage_q == LAST_STAGE);
      bfly_q     <= rd_en_c ? k_q : '0;
    end
  end

  assign iact       = iact_q;
  assign ictrl      = ictrl_q;
  assign bfly_index = bfly_q;
  assign stage      = stage_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// Directed bench for fft_butterfly_scheduler with FFT_N = 3 (8 points, 3 stages).
module tb_fft_butterfly_scheduler;

  localparam int FFT_N = 3;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       oact  = 1'b0;
`ifdef FFT_SCHED_STALL_EN
  logic       stall = 1'b0;
`endif
  logic [2:0] rd_addr_a, rd_addr_b;
  logic [1:0] twiddle_addr;
  logic       rd_en, iact;
  logic [1:0] ictrl;
  logic [1:0] bfly_index;
  logic [1:0] stage;
  logic       busy, done;
  logic [1:0] state_dbg;

  fft_butterfly_scheduler #(.FFT_N(FFT_N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
`ifdef FFT_SCHED_STALL_EN
    .stall        (stall),
`endif
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .twiddle_addr (twiddle_addr),
    .rd_en        (rd_en),
    .iact         (iact),
    .ictrl        (ictrl),
    .bfly_index   (bfly_index),
    .oact         (oact),
    .stage        (stage),
    .busy         (busy),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Hand-computed operand/twiddle table, packed {a[2:0], b[2:0], tw[1:0]}.
  logic [7:0] addr_tbl [12] = '{
    {3'd0, 3'd4, 2'd0}, {3'd1, 3'd5, 2'd1}, {3'd2, 3'd6, 2'd2}, {3'd3, 3'd7, 2'd3},
    {3'd0, 3'd2, 2'd0}, {3'd1, 3'd3, 2'd2}, {3'd4, 3'd6, 2'd0}, {3'd5, 3'd7, 2'd2},
    {3'd0, 3'd1, 2'd0}, {3'd2, 3'd3, 2'd0}, {3'd4, 3'd5, 2'd0}, {3'd6, 3'd7, 2'd0}
  };

  // Scoreboard queues: issue-side addresses and butterfly-side {ictrl, k}.
  logic [7:0] exp_q[$];
  logic [3:0] exp_i_q[$];

  // Pipeline model: oact follows iact by 6 cycles when enabled.
  logic [5:0] dl = '0;
  bit         oact_model = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled at the negedge.
  task automatic tick();
    @(negedge clk);
    if (oact_model) oact = dl[5];
    dl = {dl[4:0], iact};
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_iact"},  iact, 0);
    chk({tag, "_ictrl"}, ictrl, 0);
    chk({tag, "_bidx"},  bfly_index, 0);
    chk({tag, "_addr_a"}, rd_addr_a, 0);
    chk({tag, "_addr_b"}, rd_addr_b, 0);
    chk({tag, "_tw"},    twiddle_addr, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  // One full pass: start, then check every issue, every iact and the ending.
  task automatic run_pass(input int inject_t, input bit do_stall);
    int  issued, iacts, dones, gap, t0, t3, tl, td, stall_left;
    bit  done_seen, finished;
    logic [7:0] e;
    logic [3:0] ei;
    issued = 0; iacts = 0; dones = 0; gap = 0; t0 = 0; t3 = 0; tl = 0; td = 0;
    stall_left = do_stall ? 3 : 0;
    done_seen = 1'b0; finished = 1'b0;
    exp_q.delete();
    exp_i_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(addr_tbl[i]);
    oact_model = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 300 && !finished; t++) begin
      start = (t == inject_t);
`ifdef FFT_SCHED_STALL_EN
      if (issued == 2 && stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else begin
        stall = 1'b0;
      end
`endif
      #1;
      if (done_seen) begin
        chk("idle_after_done_busy", busy, 0);
        chk("idle_after_done_done", done, 0);
        chk("idle_after_done_state", state_dbg, 0);
        finished = 1'b1;
      end else begin
        chk("busy_during_pass", busy, 1);
        if (rd_en) begin
          if (exp_q.size() == 0) begin
            chk("extra_issue", 32'(issued), 11);
          end else begin
            e = exp_q.pop_front();
            chk("rd_addr_a", rd_addr_a, e[7:5]);
            chk("rd_addr_b", rd_addr_b, e[4:2]);
            chk("twiddle_addr", twiddle_addr, e[1:0]);
            chk("stage", stage, 32'(issued / 4));
          end
          if (issued % 4 == 0 && issued > 0) chk("drain_gap", gap, 7);
          exp_i_q.push_back({(issued == 11), (issued % 4 == 0), 2'(issued % 4)});
          if (issued == 0)  t0 = t;
          if (issued == 3)  t3 = t;
          if (issued == 11) tl = t;
          issued++;
          gap = 0;
        end else begin
          gap++;
        end
        if (iact) begin
          if (exp_i_q.size() == 0) begin
            chk("extra_iact", 32'(iacts), 11);
          end else begin
            ei = exp_i_q.pop_front();
            chk("ictrl", ictrl, ei[3:2]);
            chk("bfly_index", bfly_index, ei[1:0]);
          end
          iacts++;
        end
        if (done) begin
          dones++;
          td = t;
          done_seen = 1'b1;
        end
      end
      if (!finished) tick();
    end
    start = 1'b0;
    oact_model = 1'b0;
    oact = 1'b0;
    chk("pass_finished", finished, 1);
    chk("issue_total", issued, 12);
    chk("iact_total", iacts, 12);
    chk("done_pulses", dones, 1);
    chk("done_latency", td - tl, 8);
    chk("stage0_issue_span", t3 - t0, do_stall ? 6 : 3);
    chk("scoreboard_empty", exp_q.size() + exp_i_q.size(), 0);
  endtask

  initial begin
    // Reset state.
    #2;
    chk_all_zero("reset");
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // oact pulses while idle must not start or disturb anything.
    for (int i = 0; i < 3; i++) begin
      oact = 1'b1;
      tick();
      chk("idle_oact_state", state_dbg, 0);
      chk("idle_oact_busy", busy, 0);
      chk("idle_oact_done", done, 0);
    end
    oact = 1'b0;
    tick();

    // Plain pass.
    run_pass(-1, 1'b0);
    tick();

    // Pass with a start pulse in the middle of stage 1 (must be ignored).
    run_pass(14, 1'b0);
    tick();

    // Reset in the middle of stage 1 issue.
    oact_model = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("pre_reset_stage", stage, 1);
    chk("pre_reset_rd_en", rd_en, 1);
    chk("pre_reset_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    oact_model = 1'b0;
    oact = 1'b0;
    dl = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_all_zero("after_mid_reset");
    run_pass(-1, 1'b0);
    tick();

`ifdef FFT_SCHED_STALL_EN
    // Stall for three cycles at k=2 of stage 0.
    run_pass(-1, 1'b1);
    tick();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
